// File: rtl/trigger_pkg.sv
// Shared types, edge-mode codes and threshold arithmetic for level_trigger_hyst.
package trigger_pkg;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;

    typedef enum logic [1:0] {
        QUALIFY = 2'd0,
        HOLDOFF = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Working width for threshold maths; supports DATA_W up to 63. Operands are
    // sign/zero-extended copies of DATA_W+1-bit values, so results never wrap.
    localparam int ARITH_W = 64;

    function automatic logic signed [ARITH_W-1:0] band_edge(
        input logic signed [ARITH_W-1:0] level_x,
        input logic signed [ARITH_W-1:0] hyst_x,
        input logic                      upper
    );
        return upper ? (level_x + hyst_x) : (level_x - hyst_x);
    endfunction

endpackage

// File: rtl/level_trigger_hyst_if.sv
// Sample stream into level_trigger_hyst.
// Handshake: valid-only stream; a sample is consumed on every clk edge where
// data_in_valid is high, the sink has no ready and never stalls.
interface level_trigger_hyst_if #(
    parameter int DATA_W = 32
);
    logic signed [DATA_W-1:0] data_in;
    logic                     data_in_valid;

    modport master (output data_in, output data_in_valid);
    modport slave  (input  data_in, input  data_in_valid);
endinterface

// File: rtl/trigger_crossing_det.sv
// Threshold band computation, hysteresis qualification flags and the raw
// crossing condition for the current valid sample.
module trigger_crossing_det
    import trigger_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] level,
    input  logic        [DATA_W-2:0] hyst,
    input  logic        [1:0]        edge_mode,
    output logic                     crossing
);

    logic signed [ARITH_W-1:0] level_w;
    logic signed [ARITH_W-1:0] hyst_w;
    logic signed [ARITH_W-1:0] sample_w;
    logic signed [ARITH_W-1:0] lo_w;
    logic signed [ARITH_W-1:0] hi_w;
    logic                      qual_lo;
    logic                      qual_hi;
    logic                      rise;
    logic                      fall;

    assign level_w  = {{(ARITH_W-DATA_W){level[DATA_W-1]}}, level};
    assign sample_w = {{(ARITH_W-DATA_W){sample[DATA_W-1]}}, sample};
    assign hyst_w   = {{(ARITH_W-DATA_W+1){1'b0}}, hyst};
    assign lo_w     = band_edge(level_w, hyst_w, 1'b0);
    assign hi_w     = band_edge(level_w, hyst_w, 1'b1);

    // Flags hold what earlier samples proved; clear wins so the sample that
    // fires (or is swallowed by holdoff) can never requalify itself.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            qual_lo <= 1'b0;
            qual_hi <= 1'b0;
        end else if (sample_valid) begin
            if (sample_w <= lo_w) qual_lo <= 1'b1;
            if (sample_w >= hi_w) qual_hi <= 1'b1;
        end
    end

    always_comb begin
        rise     = qual_lo && (sample_w > level_w);
        fall     = qual_hi && (sample_w < level_w);
        crossing = 1'b0;
        if (sample_valid) begin
            case (edge_mode)
                EDGE_RISE: crossing = rise;
                EDGE_FALL: crossing = fall;
                EDGE_BOTH: crossing = rise | fall;
                default:   crossing = rise;
            endcase
        end
    end

endmodule

// File: rtl/level_trigger_hyst.sv
// Level-crossing trigger with hysteresis, holdoff and single-shot/auto-rearm.
// Build option: define TRIGGER_TIMESTAMP_EN to latch a valid-sample index per event.
module level_trigger_hyst
    import trigger_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int HOLDOFF_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     arm,
    level_trigger_hyst_if.slave      smp,
    input  logic signed [DATA_W-1:0] cfg_level,
    input  logic        [DATA_W-2:0] cfg_hyst,
    input  logic        [1:0]        cfg_edge,
    input  logic                     cfg_auto_rearm,
    input  logic [HOLDOFF_W-1:0]     cfg_holdoff,
    output logic                     trigger,
    output logic                     armed,
    output logic [CNT_W-1:0]         trig_count,
    output logic [31:0]              trig_timestamp,
    output state_t                   dbg_state
);

    state_t                   state;
    state_t                   state_nxt;
    logic [HOLDOFF_W-1:0]     hold_cnt;
    logic [HOLDOFF_W-1:0]     hold_nxt;
    logic                     fire;
    logic                     det_clear;
    logic                     crossing;
    logic                     cfg_loaded;
    logic                     load;

    logic signed [DATA_W-1:0] sh_level;
    logic        [DATA_W-2:0] sh_hyst;
    logic        [1:0]        sh_edge;
    logic                     sh_auto;
    logic [HOLDOFF_W-1:0]     sh_holdoff;

    // The first clk after reset release behaves exactly like an arm pulse.
    assign load      = arm | ~cfg_loaded;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg_loaded <= 1'b0;
            sh_level   <= '0;
            sh_hyst    <= '0;
            sh_edge    <= EDGE_RISE;
            sh_auto    <= 1'b0;
            sh_holdoff <= '0;
        end else begin
            cfg_loaded <= 1'b1;
            if (load) begin
                sh_level   <= cfg_level;
                sh_hyst    <= cfg_hyst;
                sh_edge    <= cfg_edge;
                sh_auto    <= cfg_auto_rearm;
                sh_holdoff <= cfg_holdoff;
            end
        end
    end

    trigger_crossing_det #(
        .DATA_W (DATA_W)
    ) u_det (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (det_clear),
        .sample_valid (smp.data_in_valid),
        .sample       (smp.data_in),
        .level        (sh_level),
        .hyst         (sh_hyst),
        .edge_mode    (sh_edge),
        .crossing     (crossing)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= QUALIFY;
            hold_cnt <= '0;
            trigger  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            trigger  <= fire;
            armed    <= (state_nxt == QUALIFY);
        end
    end

    // Flags are held clear outside QUALIFY so every re-entry starts fresh.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        fire      = 1'b0;
        det_clear = 1'b0;
        if (load) begin
            state_nxt = QUALIFY;
            hold_nxt  = '0;
            det_clear = 1'b1;
        end else begin
            case (state)
                QUALIFY: begin
                    if (crossing) begin
                        fire      = 1'b1;
                        det_clear = 1'b1;
                        if (sh_holdoff != '0) begin
                            state_nxt = HOLDOFF;
                            hold_nxt  = sh_holdoff;
                        end else if (!sh_auto) begin
                            state_nxt = DONE;
                        end
                    end
                end
                HOLDOFF: begin
                    det_clear = 1'b1;
                    if (smp.data_in_valid) begin
                        if (hold_cnt <= HOLDOFF_W'(1)) begin
                            hold_nxt  = '0;
                            state_nxt = sh_auto ? QUALIFY : DONE;
                        end else begin
                            hold_nxt = hold_cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    det_clear = 1'b1;
                end
                default: begin
                    state_nxt = QUALIFY;
                    det_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trig_count <= '0;
        end else if (fire && (trig_count != '1)) begin
            trig_count <= trig_count + 1'b1;
        end
    end

`ifdef TRIGGER_TIMESTAMP_EN
    logic [31:0] sample_idx;
    logic [31:0] ts_q;

    // Index of the current valid sample since reset/arm; wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset_n || load) begin
            sample_idx <= '0;
        end else if (smp.data_in_valid) begin
            sample_idx <= sample_idx + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else if (fire) begin
            ts_q <= sample_idx;
        end
    end

    assign trig_timestamp = ts_q;
`else
    assign trig_timestamp = '0;
`endif

endmodule

// File: tb/tb_level_trigger_hyst.sv
// Directed-vector bench for level_trigger_hyst (CNT_W=4 to reach saturation).
module tb_level_trigger_hyst;
  import trigger_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        arm;
  logic signed [31:0] cfg_level;
  logic [30:0] cfg_hyst;
  logic [1:0]  cfg_edge;
  logic        cfg_auto_rearm;
  logic [15:0] cfg_holdoff;
  logic        trigger;
  logic        armed;
  logic [3:0]  trig_count;
  logic [31:0] trig_timestamp;
  state_t      dbg_state;

  int vectors = 0;
  int miscompares = 0;

  level_trigger_hyst_if #(.DATA_W(32)) bus ();

  level_trigger_hyst #(
    .DATA_W    (32),
    .HOLDOFF_W (16),
    .CNT_W     (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .arm            (arm),
    .smp            (bus),
    .cfg_level      (cfg_level),
    .cfg_hyst       (cfg_hyst),
    .cfg_edge       (cfg_edge),
    .cfg_auto_rearm (cfg_auto_rearm),
    .cfg_holdoff    (cfg_holdoff),
    .trigger        (trigger),
    .armed          (armed),
    .trig_count     (trig_count),
    .trig_timestamp (trig_timestamp),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // drivers: everything changes on negedge, observed on the following negedge
  task automatic put(input int v, output logic trg);
    bus.data_in = v;
    bus.data_in_valid = 1'b1;
    @(negedge clk);
    trg = trigger;
    bus.data_in_valid = 1'b0;
  endtask

  task automatic configure(input int lvl, input int hy, input int e, input int au, input int ho);
    cfg_level = lvl;
    cfg_hyst = 31'(hy);
    cfg_edge = 2'(e);
    cfg_auto_rearm = (au != 0);
    cfg_holdoff = 16'(ho);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (trigger !== 1'b0) begin miscompares++; $display("FAIL reset trigger: got %b want 0", trigger); end
    if (armed !== 1'b0) begin miscompares++; $display("FAIL reset armed: got %b want 0", armed); end
    if (trig_count !== 4'd0) begin miscompares++; $display("FAIL reset trig_count: got %0d want 0", trig_count); end
    if (trig_timestamp !== 32'd0) begin miscompares++; $display("FAIL reset trig_timestamp: got %0d want 0", trig_timestamp); end
    reset_n = 1'b1;
    @(negedge clk);
    vectors += 2;
    if (armed !== 1'b1) begin miscompares++; $display("FAIL post-reset armed: got %b want 1", armed); end
    if (dbg_state !== QUALIFY) begin miscompares++; $display("FAIL post-reset state: got %0d want QUALIFY", dbg_state); end
  endtask

  task automatic test_rising_single();
    int   s[4];
    logic e[4];
    logic trg;
    configure(4000, 0, 0, 0, 0);
    cfg_level = -99999;  // must be ignored until the next arm
    s = '{3900, 4100, 3900, 4200};
    e = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      put(s[i], trg);
      vectors++;
      if (trg !== e[i]) begin miscompares++; $display("FAIL rise[%0d] trigger: got %b want %b", i, trg, e[i]); end
    end
    vectors += 2;
    if (dbg_state !== DONE) begin miscompares++; $display("FAIL rise done state: got %0d want DONE", dbg_state); end
    if (armed !== 1'b0) begin miscompares++; $display("FAIL rise done armed: got %b want 0", armed); end
    configure(4000, 0, 0, 0, 0);
    put(3900, trg);
    vectors++;
    if (trg !== 1'b0) begin miscompares++; $display("FAIL rearm 3900 trigger: got %b want 0", trg); end
    put(4100, trg);
    vectors += 2;
    if (trg !== 1'b1) begin miscompares++; $display("FAIL rearm 4100 trigger: got %b want 1", trg); end
    if (trig_count !== 4'd2) begin miscompares++; $display("FAIL rise trig_count: got %0d want 2", trig_count); end
  endtask

  task automatic test_hysteresis();
    int   s[9];
    logic e[9];
    logic trg;
    configure(4000, 100, 0, 1, 0);
    s = '{3950, 4050, 3950, 4050, 3900, 4001, 4100, 3800, 4100};
    e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      put(s[i], trg);
      vectors++;
      if (trg !== e[i]) begin miscompares++; $display("FAIL hyst[%0d] trigger: got %b want %b", i, trg, e[i]); end
    end
    vectors++;
    if (trig_count !== 4'd4) begin miscompares++; $display("FAIL hyst trig_count: got %0d want 4", trig_count); end
  endtask

  task automatic test_both_edges();
    int   s[8];
    logic e[8];
    logic trg;
    configure(0, 10, 2, 1, 0);
    s = '{20, -20, -20, 20, 20, -20, 5, -5};
    e = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      put(s[i], trg);
      vectors++;
      if (trg !== e[i]) begin miscompares++; $display("FAIL both[%0d] trigger: got %b want %b", i, trg, e[i]); end
    end
    vectors++;
    if (trig_count !== 4'd7) begin miscompares++; $display("FAIL both trig_count: got %0d want 7", trig_count); end
  endtask

  task automatic test_holdoff();
    int   s[6];
    logic e[6];
    logic trg;
    configure(0, 0, 0, 1, 3);
    put(-5000, trg);
    put(5000, trg);
    vectors++;
    if (trg !== 1'b1) begin miscompares++; $display("FAIL hold first trigger: got %b want 1", trg); end
    put(-5000, trg);
    repeat (4) @(negedge clk);
    vectors++;
    if (dbg_state !== HOLDOFF) begin miscompares++; $display("FAIL hold frozen state: got %0d want HOLDOFF", dbg_state); end
    put(5000, trg);
    vectors++;
    if (trg !== 1'b0) begin miscompares++; $display("FAIL hold 2nd sample trigger: got %b want 0", trg); end
    put(-5000, trg);
    vectors++;
    if (armed !== 1'b1) begin miscompares++; $display("FAIL hold rearm armed: got %b want 1", armed); end
    s = '{5000, -5000, 5000, 0, 0, 0};
    e = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      put(s[i], trg);
      vectors++;
      if (trg !== e[i]) begin miscompares++; $display("FAIL hold_auto[%0d] trigger: got %b want %b", i, trg, e[i]); end
    end
    // single-shot still waits out its holdoff before going inert
    configure(0, 0, 0, 0, 2);
    s = '{-5000, 5000, -5000, 5000, -5000, 5000};
    e = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      put(s[i], trg);
      vectors++;
      if (trg !== e[i]) begin miscompares++; $display("FAIL hold_single[%0d] trigger: got %b want %b", i, trg, e[i]); end
    end
    vectors += 2;
    if (dbg_state !== DONE) begin miscompares++; $display("FAIL hold single state: got %0d want DONE", dbg_state); end
    if (trig_count !== 4'd10) begin miscompares++; $display("FAIL hold trig_count: got %0d want 10", trig_count); end
  endtask

  task automatic test_extremes();
    int   s[5];
    logic e[5];
    logic trg;
    configure(32'sh7FFF_FF00, 32'h7FFF_FFFF, 1, 1, 0);
    s = '{32'sh7FFF_FFFF, 0, 32'sh8000_0000, 32'sh7FFF_FFFF, 0};
    e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      put(s[i], trg);
      vectors++;
      if (trg !== e[i]) begin miscompares++; $display("FAIL extreme_fall[%0d] trigger: got %b want %b", i, trg, e[i]); end
    end
    configure(32'sh7FFF_FF00, 32'h7FFF_FFFF, 0, 1, 0);
    put(32'sh8000_0000, trg);
    vectors++;
    if (trg !== 1'b0) begin miscompares++; $display("FAIL extreme_rise qual trigger: got %b want 0", trg); end
    put(32'sh7FFF_FFFF, trg);
    vectors += 2;
    if (trg !== 1'b1) begin miscompares++; $display("FAIL extreme_rise fire trigger: got %b want 1", trg); end
    if (trig_count !== 4'd11) begin miscompares++; $display("FAIL extreme trig_count: got %0d want 11", trig_count); end
  endtask

  task automatic test_arm_vs_event();
    logic trg;
    configure(0, 0, 0, 1, 0);
    put(-5, trg);
    bus.data_in = 5;
    bus.data_in_valid = 1'b1;
    arm = 1'b1;
    @(negedge clk);
    trg = trigger;
    arm = 1'b0;
    bus.data_in_valid = 1'b0;
    vectors += 3;
    if (trg !== 1'b0) begin miscompares++; $display("FAIL arm_vs_event trigger: got %b want 0", trg); end
    if (armed !== 1'b1) begin miscompares++; $display("FAIL arm_vs_event armed: got %b want 1", armed); end
    if (trig_count !== 4'd11) begin miscompares++; $display("FAIL arm_vs_event trig_count: got %0d want 11", trig_count); end
    put(5, trg);
    vectors++;
    if (trg !== 1'b0) begin miscompares++; $display("FAIL arm_vs_event flags trigger: got %b want 0", trg); end
  endtask

  task automatic test_timestamp();
    logic trg;
    logic [31:0] exp_ts;
`ifdef TRIGGER_TIMESTAMP_EN
    exp_ts = 32'd6;
`else
    exp_ts = 32'd0;
`endif
    configure(0, 0, 0, 0, 0);
    repeat (6) put(-1, trg);
    put(1, trg);
    vectors += 3;
    if (trg !== 1'b1) begin miscompares++; $display("FAIL ts trigger: got %b want 1", trg); end
    if (trig_timestamp !== exp_ts) begin miscompares++; $display("FAIL ts value: got %0d want %0d", trig_timestamp, exp_ts); end
    if (trig_count !== 4'd12) begin miscompares++; $display("FAIL ts trig_count: got %0d want 12", trig_count); end
  endtask

  task automatic test_saturation();
    logic trg;
    configure(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      put(-1, trg);
      put(1, trg);
      vectors++;
      if (trg !== 1'b1) begin miscompares++; $display("FAIL sat[%0d] trigger: got %b want 1", i, trg); end
    end
    vectors++;
    if (trig_count !== 4'd15) begin miscompares++; $display("FAIL sat trig_count: got %0d want 15", trig_count); end
  endtask

  initial begin
    reset_n = 1'b0;
    arm = 1'b0;
    cfg_level = 0;
    cfg_hyst = '0;
    cfg_edge = 2'd0;
    cfg_auto_rearm = 1'b0;
    cfg_holdoff = '0;
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    test_reset();
    test_rising_single();
    test_hysteresis();
    test_both_edges();
    test_holdoff();
    test_extremes();
    test_arm_vs_event();
    test_timestamp();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
